// File: rtl/mon_tx_scheduler.sv
// Purpose : shares the 40-bit monitor transmit path among audio, keyboard and status requesters.
// Latency : a request seen on edge t drives out_valid after edge t+1; later frames follow at FRAME_GAP-cycle spacing.
// Backpres: keyboard/status ready = slot empty; audio cannot be stalled, so a repeat request is merged and flagged as overrun.
module mon_tx_scheduler #(
   parameter int unsigned FRAME_GAP    = 48,
   parameter logic [7:0]  OP_AUDIO_REQ = 8'hC7,
   parameter logic [7:0]  OP_KBD       = 8'hC5,
   parameter logic [7:0]  OP_STATUS    = 8'hC6
) (
   input  logic        mon_clk,
   input  logic        reset_n,
   input  logic        audio_req,
   input  logic        kbd_valid,
   input  logic [31:0] kbd_data,
   output logic        kbd_ready,
   input  logic        status_valid,
   input  logic [31:0] status_data,
   output logic        status_ready,
   output logic [39:0] out_data,
   output logic        out_valid,
   output logic        audio_overrun,
   output logic        busy
);

   typedef enum logic {
      S_IDLE = 1'b0,
      S_GAP  = 1'b1
   } state_t;

   // Counter reload so that the next issue lands exactly FRAME_GAP edges later.
   localparam logic [7:0] GAP_RELOAD = 8'(FRAME_GAP - 1);

   // Round-robin pointer encoding between the two non-audio requesters.
   localparam logic RR_KBD = 1'b0;
   localparam logic RR_STS = 1'b1;

   state_t      r_state;
   logic [7:0]  r_cnt;
   logic        r_rr;

   logic        r_aud_pend;
   logic        r_kbd_pend;
   logic [31:0] r_kbd_dat;
   logic        r_sts_pend;
   logic [31:0] r_sts_dat;

   logic        r_out_vld;
   logic [39:0] r_out_dat;
   logic        r_ovr;

   logic        w_any_pend;
   logic        w_slot_open;
   logic        w_issue;
   logic        w_iss_aud;
   logic        w_iss_kbd;
   logic        w_iss_sts;
   logic        w_kbd_acc;
   logic        w_sts_acc;
   logic [39:0] w_iss_dat;

   assign w_any_pend  = r_aud_pend | r_kbd_pend | r_sts_pend;
   // An issue opportunity exists when idle, or on the last cycle of the gap.
   assign w_slot_open = (r_state == S_IDLE) || (r_cnt == 8'd0);
   assign w_issue     = w_slot_open & w_any_pend;

   // Audio has absolute priority; rr only breaks a keyboard/status tie.
   assign w_iss_aud = w_issue & r_aud_pend;
   assign w_iss_kbd = w_issue & ~r_aud_pend & r_kbd_pend & (~r_sts_pend | (r_rr == RR_KBD));
   assign w_iss_sts = w_issue & ~r_aud_pend & r_sts_pend & (~r_kbd_pend | (r_rr == RR_STS));

   assign w_kbd_acc = kbd_valid & ~r_kbd_pend;
   assign w_sts_acc = status_valid & ~r_sts_pend;

   assign kbd_ready     = ~r_kbd_pend;
   assign status_ready  = ~r_sts_pend;
   assign out_data      = r_out_dat;
   assign out_valid     = r_out_vld;
   assign audio_overrun = r_ovr;
   assign busy          = (r_state == S_GAP) | w_any_pend;

   // Frame word of whichever slot wins this opportunity.
   always_comb begin
      w_iss_dat = 40'h0;
      if (w_iss_aud) begin
         w_iss_dat = {OP_AUDIO_REQ, 32'h0};
      end else if (w_iss_kbd) begin
         w_iss_dat = {OP_KBD, r_kbd_dat};
      end else if (w_iss_sts) begin
         w_iss_dat = {OP_STATUS, r_sts_dat};
      end
   end

   // Audio slot: a new request outranks the clear from a same-edge issue.
   always_ff @(posedge mon_clk or negedge reset_n) begin
      if (!reset_n) begin
         r_aud_pend <= 1'b0;
      end else if (audio_req) begin
         r_aud_pend <= 1'b1;
      end else if (w_iss_aud) begin
         r_aud_pend <= 1'b0;
      end
   end

   // Keyboard slot: load on valid&ready, clear on issue.
   always_ff @(posedge mon_clk or negedge reset_n) begin
      if (!reset_n) begin
         r_kbd_pend <= 1'b0;
         r_kbd_dat  <= 32'h0;
      end else if (w_kbd_acc) begin
         r_kbd_pend <= 1'b1;
         r_kbd_dat  <= kbd_data;
      end else if (w_iss_kbd) begin
         r_kbd_pend <= 1'b0;
      end
   end

   // Status slot: load on valid&ready, clear on issue.
   always_ff @(posedge mon_clk or negedge reset_n) begin
      if (!reset_n) begin
         r_sts_pend <= 1'b0;
         r_sts_dat  <= 32'h0;
      end else if (w_sts_acc) begin
         r_sts_pend <= 1'b1;
         r_sts_dat  <= status_data;
      end else if (w_iss_sts) begin
         r_sts_pend <= 1'b0;
      end
   end

   // Overrun: a request lands on a pending audio slot that is not draining this edge.
   always_ff @(posedge mon_clk or negedge reset_n) begin
      if (!reset_n) begin
         r_ovr <= 1'b0;
      end else begin
         r_ovr <= audio_req & r_aud_pend & ~w_iss_aud;
      end
   end

   // Issue/gap state machine with registered frame outputs and rr pointer.
   always_ff @(posedge mon_clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state   <= S_IDLE;
         r_cnt     <= 8'd0;
         r_rr      <= RR_KBD;
         r_out_vld <= 1'b0;
         r_out_dat <= 40'h0;
      end else begin
         r_out_vld <= 1'b0;
         if (w_issue) begin
            r_state   <= S_GAP;
            r_cnt     <= GAP_RELOAD;
            r_out_vld <= 1'b1;
            r_out_dat <= w_iss_dat;
            if (w_iss_kbd) begin
               r_rr <= RR_STS;
            end else if (w_iss_sts) begin
               r_rr <= RR_KBD;
            end
         end else begin
            case (r_state)
               S_IDLE: begin
                  r_cnt <= 8'd0;
               end
               S_GAP: begin
                  if (r_cnt != 8'd0) begin
                     r_cnt <= r_cnt - 8'd1;
                  end else begin
                     r_state <= S_IDLE;
                  end
               end
               default: begin
                  r_state <= S_IDLE;
                  r_cnt   <= 8'd0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_mon_tx_scheduler.sv
// Directed bench for mon_tx_scheduler: a time-based reference model checked every cycle,
// plus literal expectations on frame order, payloads, latency and spacing.
module tb_mon_tx_scheduler;

   localparam int FRAME_GAP = 48;

   logic        mon_clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        audio_req = 1'b0;
   logic        kbd_valid = 1'b0;
   logic [31:0] kbd_data = 32'h0;
   logic        kbd_ready;
   logic        status_valid = 1'b0;
   logic [31:0] status_data = 32'h0;
   logic        status_ready;
   logic [39:0] out_data;
   logic        out_valid;
   logic        audio_overrun;
   logic        busy;

   int total = 0;
   int bad   = 0;

   mon_tx_scheduler #(
      .FRAME_GAP   (FRAME_GAP),
      .OP_AUDIO_REQ(8'hC7),
      .OP_KBD      (8'hC5),
      .OP_STATUS   (8'hC6)
   ) dut (
      .mon_clk      (mon_clk),
      .reset_n      (reset_n),
      .audio_req    (audio_req),
      .kbd_valid    (kbd_valid),
      .kbd_data     (kbd_data),
      .kbd_ready    (kbd_ready),
      .status_valid (status_valid),
      .status_data  (status_data),
      .status_ready (status_ready),
      .out_data     (out_data),
      .out_valid    (out_valid),
      .audio_overrun(audio_overrun),
      .busy         (busy)
   );

   always #5 mon_clk = ~mon_clk;

   function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endfunction

   // Free-running edge counter used to time-stamp observations.
   int tcyc = 0;
   always @(posedge mon_clk) tcyc <= tcyc + 1;

   // Reference model: a frame may leave on any edge where something is pending
   // and at least FRAME_GAP edges have passed since the previous frame.
   int          m_cyc, m_last;
   bit          m_ap, m_kp, m_sp, m_rr;   // m_rr: 0 favours keyboard, 1 favours status
   logic [31:0] m_kd, m_sd;
   bit          e_valid, e_ovr, e_busy;
   logic [39:0] e_data;
   bit          k_acc, s_acc, i_a, i_k, i_s;

   always @(posedge mon_clk or negedge reset_n) begin
      if (!reset_n) begin
         m_cyc = 0; m_last = -1000;
         m_ap = 0; m_kp = 0; m_sp = 0; m_rr = 0;
         m_kd = 0; m_sd = 0;
         e_valid = 0; e_ovr = 0; e_busy = 0; e_data = 40'h0;
      end else begin
         k_acc = kbd_valid && !m_kp;
         s_acc = status_valid && !m_sp;
         i_a = 0; i_k = 0; i_s = 0;
         if ((m_ap || m_kp || m_sp) && (m_cyc - m_last >= FRAME_GAP)) begin
            if (m_ap)              i_a = 1;
            else if (m_kp && m_sp) begin if (m_rr) i_s = 1; else i_k = 1; end
            else if (m_kp)         i_k = 1;
            else                   i_s = 1;
            m_last = m_cyc;
         end
         e_valid = i_a || i_k || i_s;
         if (i_a) e_data = {8'hC7, 32'h0};
         if (i_k) e_data = {8'hC5, m_kd};
         if (i_s) e_data = {8'hC6, m_sd};
         e_ovr = audio_req && m_ap && !i_a;
         if (i_a) m_ap = 0;
         if (i_k) begin m_kp = 0; m_rr = 1; end
         if (i_s) begin m_sp = 0; m_rr = 0; end
         if (audio_req) m_ap = 1;
         if (k_acc) begin m_kp = 1; m_kd = kbd_data; end
         if (s_acc) begin m_sp = 1; m_sd = status_data; end
         e_busy = (m_cyc - m_last < FRAME_GAP) || m_ap || m_kp || m_sp;
         m_cyc++;
      end
   end

   // Cycle-by-cycle comparison against the model.
   always @(negedge mon_clk) begin
      if (reset_n) begin
         check("out_valid",     out_valid,     e_valid);
         check("out_data",      out_data,      e_data);
         check("audio_overrun", audio_overrun, e_ovr);
         check("busy",          busy,          e_busy);
         check("kbd_ready",     kbd_ready,     !m_kp);
         check("status_ready",  status_ready,  !m_sp);
      end
   end

   // Frame / event log for the directed checks.
   logic [39:0] fdat[$];
   int          fcyc[$];
   int          novr = 0;
   int          last_fall = -1;
   bit          prev_busy = 0;
   always @(negedge mon_clk) begin
      if (reset_n) begin
         if (out_valid) begin
            fdat.push_back(out_data);
            fcyc.push_back(tcyc);
         end
         if (audio_overrun) novr++;
         if (prev_busy && !busy) last_fall = tcyc;
         prev_busy = busy;
      end else begin
         prev_busy = 0;
      end
   end

   task automatic clear_log();
      fdat.delete();
      fcyc.delete();
   endtask

   task automatic check_frame(string name, int idx, logic [39:0] exp);
      if (idx < fdat.size()) check(name, fdat[idx], exp);
      else check(name, 64'hDEAD, exp);
   endtask

   task automatic check_space(string name, int idx, int exp);
      if (idx < fcyc.size()) check(name, 64'(fcyc[idx] - fcyc[idx-1]), 64'(exp));
      else check(name, 64'hDEAD, 64'(exp));
   endtask

   task automatic ticks(int n);
      repeat (n) @(negedge mon_clk);
   endtask

   int rq, ov0;

   initial begin
      // Reset values
      ticks(3);
      check("rst_out_valid", out_valid, 1'b0);
      check("rst_out_data",  out_data, 40'h0);
      check("rst_overrun",   audio_overrun, 1'b0);
      check("rst_busy",      busy, 1'b0);
      check("rst_kbd_ready", kbd_ready, 1'b1);
      check("rst_sts_ready", status_ready, 1'b1);
      reset_n = 1'b1;
      ticks(2);

      // Single audio request: 2-edge latency, busy falls one gap after the frame.
      clear_log();
      rq = tcyc;
      audio_req = 1'b1;
      ticks(1);
      audio_req = 1'b0;
      ticks(60);
      check("t1_nframes", fdat.size(), 1);
      check_frame("t1_data", 0, 40'hC7_00000000);
      if (fcyc.size() > 0) begin
         check("t1_latency", 64'(fcyc[0] - rq), 64'd2);
         check("t1_busy_fall", 64'(last_fall - fcyc[0]), 64'd48);
      end else begin
         check("t1_latency", 64'hDEAD, 64'd2);
      end

      // Keyboard and status offered together.
      clear_log();
      kbd_valid = 1'b1;    kbd_data = 32'h1234ABCD;
      status_valid = 1'b1; status_data = 32'h0000_0055;
      ticks(1);
      kbd_valid = 1'b0; status_valid = 1'b0;
      check("t2_kbd_ready_full", kbd_ready, 1'b0);
      check("t2_sts_ready_full", status_ready, 1'b0);
      ticks(1);
      check("t2_kbd_ready_issue", kbd_ready, 1'b1);
      check("t2_sts_ready_wait",  status_ready, 1'b0);
      check("t2_out_valid",       out_valid, 1'b1);
      ticks(110);
      check("t2_nframes", fdat.size(), 2);
      check_frame("t2_kbd", 0, 40'hC5_1234ABCD);
      check_frame("t2_sts", 1, 40'hC6_00000055);
      check_space("t2_space", 1, 48);

      // Continuous keyboard/status with an audio request during the gap.
      clear_log();
      kbd_valid = 1'b1;    kbd_data = 32'hAAAA0001;
      status_valid = 1'b1; status_data = 32'hBBBB0002;
      ticks(10);
      audio_req = 1'b1;
      ticks(1);
      audio_req = 1'b0;
      ticks(140);
      kbd_valid = 1'b0; status_valid = 1'b0;
      ticks(160);
      check("t3_nframes", fdat.size(), 6);
      check_frame("t3_f0", 0, 40'hC5_AAAA0001);
      check_frame("t3_f1", 1, 40'hC7_00000000);
      check_frame("t3_f2", 2, 40'hC6_BBBB0002);
      check_frame("t3_f3", 3, 40'hC5_AAAA0001);
      check_space("t3_s1", 1, 48);
      check_space("t3_s2", 2, 48);
      check_space("t3_s3", 3, 48);

      // Two audio requests while audio waits behind a keyboard gap.
      clear_log();
      ov0 = novr;
      kbd_valid = 1'b1; kbd_data = 32'h0BADF00D;
      ticks(1);
      kbd_valid = 1'b0;
      ticks(5);
      audio_req = 1'b1; ticks(1); audio_req = 1'b0;
      ticks(5);
      audio_req = 1'b1; ticks(1); audio_req = 1'b0;
      ticks(100);
      check("t4_nframes", fdat.size(), 2);
      check_frame("t4_kbd", 0, 40'hC5_0BADF00D);
      check_frame("t4_aud", 1, 40'hC7_00000000);
      check("t4_overruns", novr - ov0, 1);

      // Audio request on the edge that issues audio.
      clear_log();
      ov0 = novr;
      audio_req = 1'b1;
      ticks(2);
      audio_req = 1'b0;
      ticks(110);
      check("t5_nframes", fdat.size(), 2);
      check_frame("t5_f0", 0, 40'hC7_00000000);
      check_frame("t5_f1", 1, 40'hC7_00000000);
      check_space("t5_space", 1, 48);
      check("t5_overruns", novr - ov0, 0);

      // Reset mid-gap with keyboard pending.
      clear_log();
      status_valid = 1'b1; status_data = 32'h0000_0005;
      ticks(1);
      status_valid = 1'b0;
      kbd_valid = 1'b1; kbd_data = 32'hCAFE0001;
      ticks(1);
      kbd_valid = 1'b0;
      ticks(10);
      check("t6_busy_before", busy, 1'b1);
      check("t6_kbd_pending", kbd_ready, 1'b0);
      reset_n = 1'b0;
      #1;
      check("t6_rst_out_valid", out_valid, 1'b0);
      check("t6_rst_out_data",  out_data, 40'h0);
      check("t6_rst_busy",      busy, 1'b0);
      check("t6_rst_kbd_ready", kbd_ready, 1'b1);
      check("t6_rst_sts_ready", status_ready, 1'b1);
      check("t6_rst_overrun",   audio_overrun, 1'b0);
      ticks(3);
      reset_n = 1'b1;
      clear_log();
      ticks(100);
      check("t6_no_frames", fdat.size(), 0);
      check("t6_idle_busy", busy, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      bad++;
      $display("FAIL watchdog: got timeout expected finish");
      $display("test done: total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog expired");
   end

endmodule
